// File: rtl/serial_link_scheduler.sv
// rtl/serial_link_scheduler.sv - round-robin arbiter and LSB-first serialiser for the DE2 serial link
module serial_link_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 18,
    parameter int GAP     = 2
) (
    input  logic                     input_clk_DE2,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     send_data,
    output logic                     flag,
    output logic                     busy,
    output logic [2:0]               last_id,
    output logic [15:0]              frames_sent
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = IW + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     ptr_q;
    logic [CW-1:0]     bitcnt_q;
    logic [GW-1:0]     gapcnt_q;
    // Holds the bits still to be sent; bit 0 of the word leaves directly on load.
    logic [WIDTH-2:0]  shreg_q;

    logic              arb_found;
    logic [IW-1:0]     arb_idx;
    logic [SW-1:0]     scan_slot;
    logic [WIDTH-1:0]  arb_word;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IW-1:0]     ptr_next;

    logic              load_frame;
    logic              shift_bit;
    logic              end_frame;
    logic              gap_step;

    // Round-robin pick: first active request scanning upward from ptr with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_slot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_slot = {1'b0, ptr_q} + SW'(i);
            if (scan_slot >= SW'(NUM_REQ)) begin
                scan_slot = scan_slot - SW'(NUM_REQ);
            end
            if (!arb_found && req[scan_slot[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = scan_slot[IW-1:0];
            end
        end
    end

    // Select the winner's word and build its one-hot grant.
    always_comb begin
        arb_word   = '0;
        arb_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                arb_word      = req_data[i*WIDTH +: WIDTH];
                arb_onehot[i] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it is served again only after the others.
    always_comb begin
        ptr_next = '0;
        if (arb_idx != IW'(NUM_REQ - 1)) begin
            ptr_next = arb_idx + 1'b1;
        end
    end

    // Frame sequencer: IDLE -> SHIFT (WIDTH bit cycles) -> GAP (GAP dead cycles) -> IDLE/SHIFT.
    always_comb begin
        state_d    = state_q;
        load_frame = 1'b0;
        shift_bit  = 1'b0;
        end_frame  = 1'b0;
        gap_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    load_frame = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q == CW'(WIDTH)) begin
                    end_frame = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    shift_bit = 1'b1;
                end
            end
            ST_GAP: begin
                if (gapcnt_q == GW'(GAP)) begin
                    if (arb_found) begin
                        load_frame = 1'b1;
                        state_d    = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_step = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge input_clk_DE2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch the winning word, shift it out, count frames and gap cycles.
    always_ff @(posedge input_clk_DE2 or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            send_data   <= 1'b0;
            flag        <= 1'b0;
            last_id     <= '0;
            frames_sent <= '0;
            ptr_q       <= '0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            shreg_q     <= '0;
        end else begin
            grant <= '0;
            flag  <= 1'b0;
            if (load_frame) begin
                shreg_q   <= arb_word[WIDTH-1:1];
                send_data <= arb_word[0];
                flag      <= 1'b1;
                grant     <= arb_onehot;
                last_id   <= 3'(arb_idx);
                ptr_q     <= ptr_next;
                bitcnt_q  <= CW'(1);
            end else if (shift_bit) begin
                send_data <= shreg_q[0];
                shreg_q   <= shreg_q >> 1;
                bitcnt_q  <= bitcnt_q + 1'b1;
            end else if (end_frame) begin
                send_data   <= 1'b0;
                frames_sent <= frames_sent + 1'b1;
                gapcnt_q    <= GW'(1);
            end else if (gap_step) begin
                send_data <= 1'b0;
                gapcnt_q  <= gapcnt_q + 1'b1;
            end
        end
    end

    // The link is occupied from the flag cycle through the final dead cycle.
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_link_scheduler.sv
// tb/tb_serial_link_scheduler.sv - self-checking bench for serial_link_scheduler
`timescale 1ns/1ps
module tb_serial_link_scheduler;

    localparam int NR = 4;
    localparam int W  = 18;
    localparam int G  = 2;
    localparam int PERIOD = W + G;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   grant;
    logic            send_data;
    logic            flag;
    logic            busy;
    logic [2:0]      last_id;
    logic [15:0]     frames_sent;

    serial_link_scheduler #(.NUM_REQ(NR), .WIDTH(W), .GAP(G)) dut (
        .input_clk_DE2 (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .send_data     (send_data),
        .flag          (flag),
        .busy          (busy),
        .last_id       (last_id),
        .frames_sent   (frames_sent)
    );

    always #50 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: decodes frames from flag/send_data, logs grants and flag times.
    logic [W-1:0] rx_word;
    int           rx_n;
    bit           rx_on = 0;
    int           grant_q[$];
    logic [W-1:0] word_q[$];
    int           flag_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on = 0;
        end else begin
            if (flag) begin
                rx_on = 1;
                rx_n  = 0;
                flag_q.push_back(cyc);
            end
            if (rx_on) begin
                rx_word = {send_data, rx_word[W-1:1]};
                rx_n++;
                if (rx_n == W) begin
                    word_q.push_back(rx_word);
                    rx_on = 0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (grant[i]) grant_q.push_back(i);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the design", name);
    endtask

    function automatic int oh_idx(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        req = '0;
        req_data = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        grant_q.delete();
        word_q.delete();
        flag_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output logic [NR-1:0] g, input int bound, input string name);
        g = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = grant;
                return;
            end
        end
        note_timeout(name);
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        note_timeout(name);
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_grant;
    } vec_t;

    vec_t         vecs[10];
    logic [W-1:0] words[NR];
    logic [W-1:0] sq[NR][$];
    logic [W-1:0] mq[NR][$];
    int           exp_idx[$];
    logic [W-1:0] exp_w[$];

    initial begin
        logic [NR-1:0] g;
        logic [W-1:0]  w;
        int            k;
        int            nframes;
        int            seen;
        int            age;
        int            skip;
        int            bad;
        int            mptr;
        int            left;
        bit            any;

        vecs[0] = '{4'b1010, 4'b0010};
        vecs[1] = '{4'b1111, 4'b0100};
        vecs[2] = '{4'b0111, 4'b0001};
        vecs[3] = '{4'b1000, 4'b1000};
        vecs[4] = '{4'b0110, 4'b0010};
        vecs[5] = '{4'b0011, 4'b0001};
        vecs[6] = '{4'b1101, 4'b0100};
        vecs[7] = '{4'b1100, 4'b1000};
        vecs[8] = '{4'b0000, 4'b0000};
        vecs[9] = '{4'b0101, 4'b0001};
        words[0] = 18'h2FEDC;
        words[1] = 18'h12345;
        words[2] = 18'h0A5A5;
        words[3] = 18'h3C0F3;

        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_send_data", send_data, 0);
        check("rst_flag", flag, 0);
        check("rst_busy", busy, 0);
        check("rst_last_id", last_id, 0);
        check("rst_frames_sent", frames_sent, 0);
        rst_n = 1'b1;
        any = 0;
        repeat (4) begin
            @(negedge clk);
            if (grant != 0 || flag || busy || send_data) any = 1;
        end
        check("idle_no_req_quiet", any, 0);

        // Single frame, exact bit pattern and framing.
        do_reset();
        w = 18'h2A5C5;
        req_data[W-1:0] = w;
        req = 4'b0001;
        wait_grant(g, 4, "t1_grant_wait");
        req = '0;
        check("t1_grant", g, 4'b0001);
        check("t1_flag_first", flag, 1);
        check("t1_busy", busy, 1);
        check("t1_bit0", send_data, w[0]);
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            check($sformatf("t1_bit%0d", i), send_data, w[i]);
            check($sformatf("t1_flag_low%0d", i), {flag, grant}, 0);
        end
        for (int i = 0; i < G; i++) begin
            @(negedge clk);
            check($sformatf("t1_gap%0d_data", i), {flag, send_data}, 0);
            check($sformatf("t1_gap%0d_busy", i), busy, 1);
        end
        check("t1_frames_sent", frames_sent, 1);
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        check("t1_last_id", last_id, 0);

        // Table of arbitration vectors, one frame each, pointer starting from 0.
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = words[i];
        nframes = 0;
        foreach (vecs[v]) begin
            req = vecs[v].req;
            if (vecs[v].exp_grant == '0) begin
                any = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (grant != 0 || flag || busy) any = 1;
                end
                req = '0;
                check($sformatf("tab%0d_no_grant", v), any, 0);
            end else begin
                wait_grant(g, 4, $sformatf("tab%0d_wait", v));
                req = '0;
                check($sformatf("tab%0d_grant", v), g, vecs[v].exp_grant);
                k = oh_idx(vecs[v].exp_grant);
                wait_idle(PERIOD + 10, $sformatf("tab%0d_idle", v));
                nframes++;
                check($sformatf("tab%0d_nwords", v), word_q.size(), nframes);
                if (word_q.size() > 0) check($sformatf("tab%0d_word", v), word_q[$], words[k]);
                check($sformatf("tab%0d_last_id", v), last_id, k);
                check($sformatf("tab%0d_frames", v), frames_sent, nframes);
            end
        end

        // All four requesting continuously: strict rotation and fixed frame period.
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = words[i];
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g, PERIOD + 4, $sformatf("t2_wait%0d", n));
            check($sformatf("t2_grant%0d", n), g, 4'b0001 << (n % NR));
        end
        req = '0;
        wait_idle(PERIOD + 10, "t2_idle");
        check("t2_nwords", word_q.size(), 5);
        for (int n = 0; n < word_q.size() && n < 5; n++)
            check($sformatf("t2_word%0d", n), word_q[n], words[n % NR]);
        check("t2_nflags", flag_q.size(), 5);
        for (int n = 1; n < flag_q.size(); n++)
            check($sformatf("t2_period%0d", n), flag_q[n] - flag_q[n-1], PERIOD);

        // Randomised loopback: 100 words from 3 requesters against a queue-level RR model.
        do_reset();
        skip = $urandom_range(0, NR - 1);
        for (int i = 0; i < NR; i++) begin
            sq[i].delete();
            mq[i].delete();
        end
        for (int n = 0; n < 100; n++) begin
            do k = $urandom_range(0, NR - 1); while (k == skip);
            w = W'($urandom);
            sq[k].push_back(w);
            mq[k].push_back(w);
        end
        exp_idx.delete();
        exp_w.delete();
        mptr = 0;
        left = 100;
        while (left > 0) begin
            for (int i = 0; i < NR; i++) begin
                k = (mptr + i) % NR;
                if (mq[k].size() > 0) begin
                    exp_idx.push_back(k);
                    exp_w.push_back(mq[k].pop_front());
                    mptr = (k + 1) % NR;
                    left--;
                    break;
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            req[i] = (sq[i].size() > 0);
            req_data[i*W +: W] = (sq[i].size() > 0) ? sq[i][0] : '0;
        end
        seen = 0;
        age = 1000;
        for (int c = 0; c < 2600 && seen < 100; c++) begin
            @(negedge clk);
            age++;
            if (grant != '0) begin
                k = oh_idx(grant);
                age = 0;
                seen++;
                if (k >= 0 && sq[k].size() > 0) begin
                    void'(sq[k].pop_front());
                    req[k] = (sq[k].size() > 0);
                    req_data[k*W +: W] = (sq[k].size() > 0) ? sq[k][0] : W'($urandom);
                end
            end
            if (age >= 2 && age <= 12) begin
                req[skip] = 1'($urandom_range(0, 1));
                req_data[skip*W +: W] = W'($urandom);
            end else begin
                req[skip] = 1'b0;
            end
        end
        if (seen < 100) note_timeout("t3_grants");
        req = '0;
        wait_idle(PERIOD + 10, "t3_idle");
        @(negedge clk);
        check("t3_ngrants", grant_q.size(), 100);
        check("t3_nwords", word_q.size(), 100);
        for (int i = 0; i < 100; i++) begin
            if (i < grant_q.size()) check($sformatf("t3_idx%0d", i), grant_q[i], exp_idx[i]);
            if (i < word_q.size()) check($sformatf("t3_word%0d", i), word_q[i], exp_w[i]);
        end
        bad = 0;
        for (int i = 1; i < flag_q.size(); i++) if (flag_q[i] - flag_q[i-1] != PERIOD) bad++;
        check("t3_period_errors", bad, 0);

        // Data changed one cycle after grant must not reach the frame in flight.
        do_reset();
        req_data[W-1:0] = 18'h15A3C;
        req = 4'b0001;
        wait_grant(g, 4, "t4_wait");
        req = '0;
        check("t4_grant", g, 4'b0001);
        @(negedge clk);
        req_data[W-1:0] = 18'h2C3A5;
        wait_idle(PERIOD + 10, "t4_idle");
        check("t4_nwords", word_q.size(), 1);
        if (word_q.size() > 0) check("t4_word", word_q[0], 18'h15A3C);

        // Reset in the middle of bit 9 aborts the frame at once.
        do_reset();
        w = 18'h1B2E7;
        req_data[W +: W] = w;
        req = 4'b0010;
        wait_grant(g, 4, "t5_wait");
        req = '0;
        check("t5_grant_pre", g, 4'b0010);
        repeat (9) @(negedge clk);
        check("t5_bit9", send_data, w[9]);
        #10 rst_n = 1'b0;
        #1;
        check("t5_abort_flag", flag, 0);
        check("t5_abort_send", send_data, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_grant", grant, 0);
        @(negedge clk);
        grant_q.delete();
        word_q.delete();
        flag_q.delete();
        w = 18'h0F0F1;
        req_data[2*W +: W] = w;
        req = 4'b0100;
        rst_n = 1'b1;
        wait_grant(g, 4, "t5_wait2");
        req = '0;
        check("t5_grant_post", g, 4'b0100);
        wait_idle(PERIOD + 10, "t5_idle");
        check("t5_nwords", word_q.size(), 1);
        if (word_q.size() > 0) check("t5_word", word_q[0], w);
        check("t5_frames", frames_sent, 1);
        check("t5_last_id", last_id, 2);

        // Frame counter wrap from 0xFFFF.
        do_reset();
        w = 18'h3A0C5;
        req_data[2*W +: W] = w;
        req = 4'b0100;
        wait_grant(g, 4, "t6_wait");
        req = '0;
        @(negedge clk);
        force dut.frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut.frames_sent;
        wait_idle(PERIOD + 10, "t6_idle");
        check("t6_frames_wrap", frames_sent, 16'h0000);
        check("t6_last_id", last_id, 2);
        if (word_q.size() > 0) check("t6_word", word_q[0], w);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
